// File: rtl/ram1_ctrl_pkg.sv
// Shared definitions for the RAM1 async-SRAM controller: FSM state encodings,
// direction codes and the latched request payload.
package ram1_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  // Direction as presented on read_i by the mem stage
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Request captured at acceptance; later input changes are ignored
  typedef struct packed {
    logic              dir;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // States in which the SRAM chip enable is asserted
  function automatic logic chip_selected(input state_e s);
    return (s == ST_SETUP) || (s == ST_ACCESS) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/ram1_ctrl_if.sv
// Mem-stage <-> RAM1 controller request/response handshake.
//   ram1en_i : request, active-low        read_i  : 0 = read, 1 = write
//   addr_i   : word address               wdata_i : write data
//   rdata_o  : read data (valid with done_o)
//   busy_o   : stall request              done_o  : one-cycle completion pulse
// master = mem stage, slave = ram1_ctrl.
interface ram1_ctrl_if;
  import ram1_ctrl_pkg::*;

  logic              ram1en_i;
  logic              read_i;
  logic [DATA_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output ram1en_i, read_i, addr_i, wdata_i,
    input  rdata_o, busy_o, done_o
  );

  modport slave (
    input  ram1en_i, read_i, addr_i, wdata_i,
    output rdata_o, busy_o, done_o
  );

endinterface

// File: rtl/ram1_ctrl.sv
// RAM1 controller: turns the mem-stage request into a timed async-SRAM cycle
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> [HOLD, writes only] -> DONE -> IDLE.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   bus (slave)     : mem-stage request / busy / done / read data
//   Ram1Addr        : SRAM address (request address zero-extended to ADDR_W)
//   Ram1Data        : SRAM data, driven only during write SETUP/ACCESS/HOLD
//   Ram1EN_o/OE/WE  : SRAM strobes, active-low
// Build option: RAM1_RDATA_HOLD_EN keeps rdata_o at the last read value;
// otherwise rdata_o is non-zero only during the DONE cycle of a read.
module ram1_ctrl
  import ram1_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  ram1_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] Ram1Addr,
  inout  wire  [DATA_W-1:0] Ram1Data,
  output logic              Ram1EN_o,
  output logic              Ram1OE,
  output logic              Ram1WE
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               en_q, oe_q, we_q, drv_q, done_q;
  logic               en_d, oe_d, we_d, drv_d, done_d;
  logic               wr_d;

  // Next state, request latch, read capture; strobes derived from next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.ram1en_i) begin
          req_d   = '{dir: bus.read_i, addr: bus.addr_i, wdata: bus.wdata_i};
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (req_q.dir == RW_READ) begin
            rdata_d = Ram1Data;
            state_d = ST_DONE;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
`ifndef RAM1_RDATA_HOLD_EN
        rdata_d = '0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // OE only on reads, WE only in ACCESS of writes: never both low
    wr_d   = (req_d.dir == RW_WRITE);
    en_d   = !chip_selected(state_d);
    oe_d   = !(!wr_d && ((state_d == ST_SETUP) || (state_d == ST_ACCESS)));
    we_d   = !(wr_d && (state_d == ST_ACCESS));
    drv_d  = wr_d && chip_selected(state_d);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs; reset releases the bus and strobes at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      en_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      drv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      drv_q   <= drv_d;
      done_q  <= done_d;
    end
  end

  assign Ram1Addr = ADDR_W'(req_q.addr);
  assign Ram1Data = drv_q ? req_q.wdata : {DATA_W{1'bz}};
  assign Ram1EN_o = en_q;
  assign Ram1OE   = oe_q;
  assign Ram1WE   = we_q;

  // Busy rises combinationally in the accepting cycle so the stall is immediate
  assign bus.busy_o  = rst && ((state_q != ST_IDLE) || !bus.ram1en_i);
  assign bus.done_o  = done_q;
  assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_ram1_ctrl.sv
module tb_ram1_ctrl;

`ifdef RAM1_RDATA_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  // Value seen on the data bus whenever the SRAM is deselected (DUT must not drive)
  localparam logic [15:0] PROBE = 16'hD00D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] Ram1Addr;
  wire  [15:0] Ram1Data;
  logic        Ram1EN_o, Ram1OE, Ram1WE;

  int checks = 0;
  int errors = 0;

  ram1_ctrl_if bus();

  ram1_ctrl #(.WAIT_CYCLES(2), .ADDR_W(18)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .Ram1Addr (Ram1Addr),
    .Ram1Data (Ram1Data),
    .Ram1EN_o (Ram1EN_o),
    .Ram1OE   (Ram1OE),
    .Ram1WE   (Ram1WE)
  );

  always #5 clk = ~clk;

  // SRAM model: reads while EN&OE low, writes on the rising edge of WE
  logic [15:0] mem [256];
  assign Ram1Data = (!Ram1EN_o && !Ram1OE) ? mem[Ram1Addr[7:0]] : 16'hzzzz;
  assign Ram1Data = Ram1EN_o ? PROBE : 16'hzzzz;
  always @(posedge Ram1WE) if (Ram1EN_o == 1'b0) mem[Ram1Addr[7:0]] = Ram1Data;

  typedef struct {
    string       name;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdat;   // rdata_o in the DONE cycle
    logic [15:0] idle;   // rdata_o in the following IDLE cycle
    int          lat;
    int          we_lo;
    int          oe_lo;
  } vec_t;

  function automatic vec_t mk(input string n, input logic wr, input logic [15:0] a,
                              input logic [15:0] w, input logic [15:0] rd,
                              input logic [15:0] idl);
    vec_t v;
    v.name = n; v.wr = wr; v.addr = a; v.wdata = w; v.rdat = rd; v.idle = idl;
    v.lat   = wr ? 5 : 4;
    v.we_lo = wr ? 2 : 0;
    v.oe_lo = wr ? 0 : 3;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge of the following IDLE cycle
  task automatic apply(input vec_t v, input bit perturb);
    int lat, we_lo, oe_lo, ovl, bad_a, bad_d, busy_lo;
    logic [15:0] rdat;
    logic busy_acc;
    lat = -1; we_lo = 0; oe_lo = 0; ovl = 0; bad_a = 0; bad_d = 0; busy_lo = 0;
    rdat = '0;
    bus.ram1en_i = 1'b0; bus.read_i = v.wr; bus.addr_i = v.addr; bus.wdata_i = v.wdata;
    #1 busy_acc = bus.busy_o;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.ram1en_i = 1'b1;
      if (perturb && c == 2) begin
        bus.addr_i = 16'hFFFF; bus.wdata_i = ~v.wdata; bus.read_i = ~v.wr;
      end
      if (!Ram1WE) we_lo++;
      if (!Ram1OE) oe_lo++;
      if (!Ram1WE && !Ram1OE) ovl++;
      if (!bus.busy_o) busy_lo++;
      if (!Ram1EN_o) begin
        if (Ram1Addr !== 18'(v.addr)) bad_a++;
        if (v.wr && Ram1Data !== v.wdata) bad_d++;
      end
      if (bus.done_o) begin
        lat = c; rdat = bus.rdata_o;
        break;
      end
    end
    chk({v.name, ".busy_accept"}, 32'(busy_acc), 32'd1);
    chk({v.name, ".latency"},     32'(lat),      32'(v.lat));
    chk({v.name, ".rdata_done"},  32'(rdat),     32'(v.rdat));
    chk({v.name, ".we_low"},      32'(we_lo),    32'(v.we_lo));
    chk({v.name, ".oe_low"},      32'(oe_lo),    32'(v.oe_lo));
    chk({v.name, ".oe_we_both"},  32'(ovl),      32'd0);
    chk({v.name, ".addr"},        32'(bad_a),    32'd0);
    chk({v.name, ".wdata"},       32'(bad_d),    32'd0);
    chk({v.name, ".busy_gap"},    32'(busy_lo),  32'd0);
    @(negedge clk);
    chk({v.name, ".idle_busy"},   32'(bus.busy_o),  32'd0);
    chk({v.name, ".idle_done"},   32'(bus.done_o),  32'd0);
    chk({v.name, ".idle_en"},     32'(Ram1EN_o),    32'd1);
    chk({v.name, ".idle_bus"},    32'(Ram1Data),    32'(PROBE));
    chk({v.name, ".idle_rdata"},  32'(bus.rdata_o), 32'(v.idle));
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, ".en"},    32'(Ram1EN_o),    32'd1);
    chk({nm, ".oe"},    32'(Ram1OE),      32'd1);
    chk({nm, ".we"},    32'(Ram1WE),      32'd1);
    chk({nm, ".bus"},   32'(Ram1Data),    32'(PROBE));
    chk({nm, ".addr"},  32'(Ram1Addr),    32'd0);
    chk({nm, ".rdata"}, 32'(bus.rdata_o), 32'd0);
    chk({nm, ".busy"},  32'(bus.busy_o),  32'd0);
    chk({nm, ".done"},  32'(bus.done_o),  32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h34] = 16'h5A5A;
    mem[8'hFF] = 16'hC3C3;

    vecs[0] = mk("rd_5a5a", 1'b0, 16'h1234, 16'h0000, 16'h5A5A, HOLD ? 16'h5A5A : 16'h0);
    vecs[1] = mk("wr_beef", 1'b1, 16'h1234, 16'hBEEF, HOLD ? 16'h5A5A : 16'h0,
                 HOLD ? 16'h5A5A : 16'h0);
    vecs[2] = mk("rd_beef", 1'b0, 16'h1234, 16'h0000, 16'hBEEF, HOLD ? 16'hBEEF : 16'h0);
    vecs[3] = mk("wr_1357", 1'b1, 16'h0055, 16'h1357, HOLD ? 16'hBEEF : 16'h0,
                 HOLD ? 16'hBEEF : 16'h0);
    vecs[4] = mk("rd_1357", 1'b0, 16'h0055, 16'h0000, 16'h1357, HOLD ? 16'h1357 : 16'h0);
    vecs[5] = mk("rd_c3c3", 1'b0, 16'h00FF, 16'h0000, 16'hC3C3, HOLD ? 16'hC3C3 : 16'h0);
    vecs[6] = mk("wr_0f0f", 1'b1, 16'h1234, 16'h0F0F, HOLD ? 16'hC3C3 : 16'h0,
                 HOLD ? 16'hC3C3 : 16'h0);
    vecs[7] = mk("rd_0f0f", 1'b0, 16'h1234, 16'h0000, 16'h0F0F, HOLD ? 16'h0F0F : 16'h0);

    // Reset, with a request pending: busy must still read 0
    bus.ram1en_i = 1'b0; bus.read_i = 1'b0; bus.addr_i = 16'h0; bus.wdata_i = 16'h0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    bus.ram1en_i = 1'b1;
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) apply(vecs[i], 1'b0);

    // Back-to-back write then read at the same address
    apply(mk("b2b_wr", 1'b1, 16'h1234, 16'hBEEF, HOLD ? 16'h0F0F : 16'h0,
             HOLD ? 16'h0F0F : 16'h0), 1'b0);
    apply(mk("b2b_rd", 1'b0, 16'h1234, 16'h0000, 16'hBEEF, HOLD ? 16'hBEEF : 16'h0), 1'b0);

    // Inputs changed during ACCESS must be ignored
    apply(mk("chg_rd", 1'b0, 16'h1234, 16'h0000, 16'hBEEF, HOLD ? 16'hBEEF : 16'h0), 1'b1);
    apply(mk("chg_wr", 1'b1, 16'h0055, 16'h2468, HOLD ? 16'hBEEF : 16'h0,
             HOLD ? 16'hBEEF : 16'h0), 1'b1);
    apply(mk("chg_rb", 1'b0, 16'h0055, 16'h0000, 16'h2468, HOLD ? 16'h2468 : 16'h0), 1'b0);

    // Reset in the first ACCESS cycle of a write
    bus.ram1en_i = 1'b0; bus.read_i = 1'b1; bus.addr_i = 16'h0077; bus.wdata_i = 16'hAAAA;
    @(negedge clk);
    bus.ram1en_i = 1'b1;
    @(negedge clk);
    chk("mid_rst.pre_we", 32'(Ram1WE), 32'd0);
    rst = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst.busy", 32'(bus.busy_o), 32'd0);
    chk("post_rst.en",   32'(Ram1EN_o),   32'd1);
    apply(mk("post_rst_rd", 1'b0, 16'h1234, 16'h0000, 16'hBEEF, HOLD ? 16'hBEEF : 16'h0), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
